// File: rtl/receiver.sv
// Oversampled UART receiver: start/8 data/[even parity]/stop, LSB first.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
//
// Parameter:
//   OSR        clken pulses per bit (power of two, 8..64)
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   rx         serial line, idle high, asynchronous to CLK
//   clken      one-cycle pulse at OSR x bit rate
//   rdy_clr    consumer acknowledge, clears rdy and overrun
//   data       last good received byte
//   rdy        data holds an unread byte
//   frame_err  last frame had its stop bit sampled low
//   overrun    a byte completed while rdy was still set
//   parity_err last frame failed the even-parity check
//   rx_busy    a frame is in progress
module receiver #(
  parameter int OSR = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx,
  input  logic       clken,
  input  logic       rdy_clr,
  output logic [7:0] data,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(OSR);

  localparam logic [CW-1:0] HALF = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OSR - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic          rx_q1;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitpos;
  logic [7:0]    shreg;
  logic          at_last;
  logic          good;

`ifdef UART_RX_PARITY_EN
  logic          par_bad;
  logic          perr_q;
`endif

  assign at_last = clken && (cnt == LAST);

  // Good completion: stop bit sampled high at its midpoint.
  assign good = (state == STOP) && at_last && rx_s;

  assign rx_busy = (state != IDLE);

  // Two-flop synchronizer, idles high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      bitpos    <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else if (clken) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          // Recheck mid start bit; a short low pulse is rejected.
          if (cnt == HALF) begin
            cnt    <= '0;
            bitpos <= 3'd0;
            state  <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            shreg[bitpos] <= rx_s;
            cnt           <= '0;
            bitpos        <= bitpos + 3'd1;
            if (bitpos == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == LAST) begin
            par_bad <= (^shreg) ^ rx_s;
            cnt     <= '0;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              data      <= shreg;
              frame_err <= 1'b0;
            end else begin
              frame_err <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            perr_q <= par_bad;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A completion in the same cycle as rdy_clr wins over the clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdy     <= 1'b0;
      overrun <= 1'b0;
    end else if (good) begin
      rdy     <= 1'b1;
      overrun <= rdy & ~rdy_clr;
    end else if (rdy_clr) begin
      rdy     <= 1'b0;
      overrun <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: vector table of frames plus
// hand sequences for glitch, latency, overrun clear and reset.
module tb_receiver;

  localparam int OSR = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Tick index (from start-bit tick 0) on which rdy rises.
  localparam int DONE_T = (NB - 1) * OSR + OSR / 2 + 1;

  logic       CLK = 1'b0;
  logic       RST;
  logic       rx;
  logic       clken;
  logic       rdy_clr;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       rx_busy;

  receiver #(.OSR(OSR)) dut (
    .CLK(CLK),
    .RST(RST),
    .rx(rx),
    .clken(clken),
    .rdy_clr(rdy_clr),
    .data(data),
    .rdy(rdy),
    .frame_err(frame_err),
    .overrun(overrun),
    .parity_err(parity_err),
    .rx_busy(rx_busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       stop;
    logic       clr;
    logic [7:0] e_data;
    logic       e_rdy;
    logic       e_fe;
    logic       e_ov;
    logic       e_pe;
  } vec_t;

  vec_t tbl [8];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk8(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    clken = 1'b1;
    @(negedge CLK);
    clken = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic pulse_clr();
    @(negedge CLK);
    rdy_clr = 1'b1;
    @(negedge CLK);
    rdy_clr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic stop, input bit lat,
                            input int ntick);
    logic [10:0] fr;
    int lim;
`ifdef UART_RX_PARITY_EN
    fr = {stop, p, d, 1'b0};
`else
    fr = {1'b1, stop, d, 1'b0};
`endif
    lim = (ntick == 0) ? NB * OSR : ntick;
    for (int k = 0; k < lim; k++) begin
      rx = fr[k / OSR];
      tick();
      if (lat && k == DONE_T - 1) chk1("lat_rdy_lo", rdy, 1'b0);
      if (lat && k == DONE_T) begin
        chk1("lat_rdy_hi", rdy, 1'b1);
        chk8("lat_data", data, d);
        chk1("lat_busy", rx_busy, 1'b0);
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk8({tag, "_data"}, data, 8'h00);
    chk1({tag, "_rdy"}, rdy, 1'b0);
    chk1({tag, "_fe"}, frame_err, 1'b0);
    chk1({tag, "_ov"}, overrun, 1'b0);
    chk1({tag, "_pe"}, parity_err, 1'b0);
    chk1({tag, "_busy"}, rx_busy, 1'b0);
  endtask

  initial begin
    //         d      p     stop  clr   data   rdy   fe    ov    pe
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h11, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'h22, 1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0};

    RST = 1'b1;
    rx = 1'b1;
    clken = 1'b0;
    rdy_clr = 1'b0;
    repeat (3) @(negedge CLK);
    chk_reset("rst");
    RST = 1'b0;
    idle(4);

    // Short low pulse while idle: rejected 8 clken after detection.
    for (int k = 0; k < 10; k++) begin
      rx = (k < 4) ? 1'b0 : 1'b1;
      tick();
      if (k == 8) chk1("glitch_busy_hi", rx_busy, 1'b1);
      if (k == 9) chk1("glitch_busy_lo", rx_busy, 1'b0);
    end
    chk1("glitch_rdy", rdy, 1'b0);
    idle(4);

    // First frame with latency check at the stop-bit midpoint.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0);
    idle(20);
    chk1("lat_fe", frame_err, 1'b0);
    pulse_clr();
    chk1("clr_rdy", rdy, 1'b0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].clr) pulse_clr();
      send_frame(tbl[i].d, tbl[i].p, tbl[i].stop, 1'b0, 0);
      idle(20);
      chk8($sformatf("v%0d_data", i), data, tbl[i].e_data);
      chk1($sformatf("v%0d_rdy", i), rdy, tbl[i].e_rdy);
      chk1($sformatf("v%0d_fe", i), frame_err, tbl[i].e_fe);
      chk1($sformatf("v%0d_ov", i), overrun, tbl[i].e_ov);
`ifdef UART_RX_PARITY_EN
      chk1($sformatf("v%0d_pe", i), parity_err, tbl[i].e_pe);
`else
      chk1($sformatf("v%0d_pe", i), parity_err, 1'b0);
`endif
      if (i == 3) begin
        pulse_clr();
        chk1("ovclr_rdy", rdy, 1'b0);
        chk1("ovclr_ov", overrun, 1'b0);
        chk8("ovclr_data", data, 8'h22);
      end
    end

    // Reset during data bit 3 of 0xFF, then a clean 0x5A.
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 70);
    @(negedge CLK);
    RST = 1'b1;
    rx = 1'b1;
    @(negedge CLK);
    chk_reset("midrst");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    idle(4);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 0);
    idle(20);
    chk8("post_rst_data", data, 8'h5A);
    chk1("post_rst_rdy", rdy, 1'b1);
    chk1("post_rst_fe", frame_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 SHALL have parameter OSR, default 16, oversampling clken pulses per bit; legal values are powers of two from 8 to 64.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx  input  1  serial line, idle high, asynchronous to CLK.
REQ-005 SHALL have port clken  input  1  single-CLK-cycle pulse from the baud generator at OSR x bit rate.
REQ-006 SHALL have port rdy_clr  input  1  consumer acknowledge; clears rdy and overrun.
REQ-007 SHALL have port data  output  8  last good received byte.
REQ-008 SHALL have port rdy  output  1  data holds an unread byte.
REQ-009 SHALL have port frame_err  output  1  last frame had stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  a byte completed while rdy was already set.
REQ-011 SHALL have port parity_err  output  1  last frame failed even-parity check.
REQ-012 SHALL have port rx_busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL pass rx through a two-flop synchronizer (reset value 1); all decisions use the synchronized value rx_s.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; the sample counter and the state advance only on cycles where clken=1.
REQ-015 In IDLE, on clken with rx_s=0: go to START and clear the sample counter to 0.
REQ-016 In START: increment the counter on each clken; on the clken where the counter equals OSR/2-1, go to DATA if rx_s=0, otherwise return to IDLE (glitch rejection); clear the counter in both cases.
REQ-017 In DATA: increment the counter on each clken; on the clken where the counter equals OSR-1, store rx_s in shift bit bitpos (LSB first), clear the counter, and increment bitpos; after bitpos 7, go to PARITY when the parity feature is compiled in, else to STOP.
REQ-018 In PARITY: sample at counter OSR-1 as in DATA; record a mismatch when the XOR of the 8 data bits and the parity bit is 1; go to STOP.
REQ-019 In STOP, at counter OSR-1 with rx_s=1: load data from the shift register, set rdy=1, clear frame_err, and set parity_err from the PARITY check.
REQ-020 In STOP, at counter OSR-1 with rx_s=0: leave data and rdy unchanged, set frame_err=1, set parity_err from the PARITY check.
REQ-021 In STOP, in both cases of REQ-019/REQ-020: return to IDLE on that same clken.
REQ-022 On a good completion (REQ-019) while rdy=1 and rdy_clr=0: set overrun=1; data is still overwritten with the new byte.
REQ-023 When rdy_clr=1 and a good completion occur in the same cycle: the completion wins; rdy stays 1, overrun is not set, and overrun is otherwise cleared.
REQ-024 When rdy_clr=1 with no completion in that cycle: clear rdy and overrun on the next edge; frame_err and parity_err are not affected.
REQ-025 Latency: rdy SHALL rise on the CLK edge of the clken that samples the middle of the stop bit.
REQ-026 A falling edge on rx in any state other than IDLE SHALL be ignored; a new frame is detected only in IDLE.

Reset
REQ-027 RST=1 SHALL immediately force: state IDLE, counter 0, bitpos 0, shift register 0x00, data 0x00, rdy 0, frame_err 0, overrun 0, parity_err 0, synchronizer flops 1.
REQ-028 RST asserted mid-frame SHALL abandon the frame; after RST is released, reception restarts only on a new start-bit falling edge.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: frames are start + 8 data + 1 even-parity bit + stop, and PARITY state is used.
REQ-030 Macro UART_RX_PARITY_EN undefined: frames are start + 8 data + stop, PARITY state is unreachable, and parity_err is tied to 0.

Verification
REQ-031 Send 0xA5 with OSR=16 and parity off -> data=0xA5 and rdy=1 at the stop-bit midpoint; frame_err=0.
REQ-032 Pulse rx low for 4 clken periods while idle -> returns to IDLE; rdy stays 0 and rx_busy drops after 8 clken.
REQ-033 Send 0x3C with the stop bit held low -> frame_err=1, rdy=0, data unchanged from its previous value.
REQ-034 Send 0x11 then 0x22 without asserting rdy_clr -> data=0x22, rdy=1, overrun=1; then rdy_clr=1 -> rdy=0, overrun=0.
REQ-035 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 (wrong) -> parity_err=1 and rdy=1; send 0x07 with parity bit 1 -> parity_err=0.
REQ-036 Assert RST during data bit 3 of 0xFF, then send 0x5A -> all outputs are at reset values during RST; afterwards data=0x5A and rdy=1.
